// File: rtl/note_scorer.sv
// note_scorer: judges the head note of the loader's look-ahead window on every
// tempo beat against the detected pitch and keeps score, streak, multiplier
// and hit/miss tallies. Freezes once the end-of-song code reaches the head.
module note_scorer #(
  parameter logic [7:0]  POINTS_PER_HIT = 8'd10,
  parameter logic [25:0] HOLD_MIN       = 26'd1_000_000,
  parameter int unsigned STREAK_STEP    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [25:0] tempo,
  input  logic [63:0] next_notes,
  input  logic [3:0]  detected_note,
  input  logic        detected_valid,
  output logic [15:0] score,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier,
  output logic [7:0]  hits,
  output logic [7:0]  misses,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        song_done
);

  localparam int unsigned CNT_W   = 26;
  localparam int unsigned SCORE_W = 16;
  localparam logic [3:0]  NOTE_REST = 4'd0;
  localparam logic [3:0]  NOTE_END  = 4'd15;
  localparam logic [7:0]  STEP_W    = 8'(STREAK_STEP);

  typedef enum logic {PLAYING, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
  logic [CNT_W-1:0]   run, run_n;
  logic               held, held_n;
  logic [SCORE_W-1:0] score_n;
  logic [7:0]         streak_n, hits_n, misses_n;
  logic [2:0]         mult_n;
  logic               hit_pulse_n, miss_pulse_n, song_done_n;

  // Only the head nibble is judged; the rest of the window is look-ahead.
  logic [3:0] head;
  logic       unused_window;
  assign head          = next_notes[3:0];
  assign unused_window = ^next_notes[63:4];

  // Per-cycle match, beat and hold qualification.
  logic             note_pitch, match, beat, held_now;
  logic [CNT_W-1:0] run_inc, run_adv;
  assign note_pitch = (head != NOTE_REST) && (head != NOTE_END);
  assign match      = detected_valid && (detected_note == head) && note_pitch;
  assign beat       = (beat_cnt >= tempo);
  assign run_inc    = (run == HOLD_MIN) ? run : run + 26'd1;
  assign run_adv    = match ? run_inc : '0;
  // A match on the beat cycle itself may complete the hold.
  assign held_now   = held || (run_adv == HOLD_MIN);

  // Saturating tallies and the multiplier/score for a hit.
  logic [7:0]         streak_inc, hits_inc, misses_inc, mult_div;
  logic [2:0]         mult_hit;
  logic [10:0]        points;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_hit;
  assign streak_inc = (streak == 8'hFF) ? streak : streak + 8'd1;
  assign hits_inc   = (hits   == 8'hFF) ? hits   : hits   + 8'd1;
  assign misses_inc = (misses == 8'hFF) ? misses : misses + 8'd1;
  assign mult_div   = streak_inc / STEP_W;
  assign mult_hit   = (mult_div > 8'd3) ? 3'd4 : 3'(mult_div[1:0]) + 3'd1;
  assign points     = 11'(POINTS_PER_HIT) * 11'(mult_hit);
  assign score_sum  = 17'(score) + 17'(points);
  assign score_hit  = score_sum[SCORE_W] ? 16'hFFFF : score_sum[SCORE_W-1:0];

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    beat_cnt_n   = beat_cnt;
    run_n        = run;
    held_n       = held;
    score_n      = score;
    streak_n     = streak;
    mult_n       = multiplier;
    hits_n       = hits;
    misses_n     = misses;
    hit_pulse_n  = 1'b0;
    miss_pulse_n = 1'b0;
    song_done_n  = song_done;
    case (state)
      PLAYING: begin
        run_n  = run_adv;
        held_n = held_now;
        if (beat) begin
          beat_cnt_n = '0;
          run_n      = '0;
          held_n     = 1'b0;
          if (head == NOTE_END) begin
            state_n     = DONE;
            song_done_n = 1'b1;
          end else if (head != NOTE_REST) begin
            if (held_now) begin
              streak_n    = streak_inc;
              mult_n      = mult_hit;
              score_n     = score_hit;
              hits_n      = hits_inc;
              hit_pulse_n = 1'b1;
            end else begin
              streak_n     = '0;
              mult_n       = 3'd1;
              misses_n     = misses_inc;
              miss_pulse_n = 1'b1;
            end
          end
        end else begin
          beat_cnt_n = beat_cnt + 26'd1;
        end
      end
      DONE: begin
        song_done_n = 1'b1;
      end
      default: begin
        state_n = PLAYING;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAYING;
      beat_cnt   <= '0;
      run        <= '0;
      held       <= 1'b0;
      score      <= '0;
      streak     <= '0;
      multiplier <= 3'd1;
      hits       <= '0;
      misses     <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_n;
      beat_cnt   <= beat_cnt_n;
      run        <= run_n;
      held       <= held_n;
      score      <= score_n;
      streak     <= streak_n;
      multiplier <= mult_n;
      hits       <= hits_n;
      misses     <= misses_n;
      hit_pulse  <= hit_pulse_n;
      miss_pulse <= miss_pulse_n;
      song_done  <= song_done_n;
    end
  end

endmodule

// File: tb/tb_note_scorer.sv
// tb_note_scorer: directed test-plan windows, saturation runs and randomized
// stimulus, checked every cycle against a behavioural scoring model.
module tb_note_scorer;

  localparam logic [25:0] HOLD = 26'd3;
  localparam int STEP = 8;
  localparam int PTS  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [25:0] tempo = 26'd10;
  logic [63:0] next_notes = '0;
  logic [3:0]  detected_note = '0;
  logic        detected_valid = 1'b0;
  logic [15:0] score;
  logic [7:0]  streak, hits, misses;
  logic [2:0]  multiplier;
  logic        hit_pulse, miss_pulse, song_done;

  note_scorer #(
    .POINTS_PER_HIT(8'd10),
    .HOLD_MIN(HOLD),
    .STREAK_STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .tempo(tempo), .next_notes(next_notes),
    .detected_note(detected_note), .detected_valid(detected_valid),
    .score(score), .streak(streak), .multiplier(multiplier), .hits(hits),
    .misses(misses), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-window history of match cycles; a hit is a run of
  // at least HOLD consecutive matches anywhere in the closing window.
  int m_score = 0, m_streak = 0, m_mult = 1, m_hits = 0, m_misses = 0, m_cnt = 0;
  bit m_hit = 0, m_miss = 0, m_done = 0;
  bit win[$];

  function automatic int longest_run();
    int best = 0, cur = 0;
    foreach (win[i]) begin
      cur  = win[i] ? cur + 1 : 0;
      best = (cur > best) ? cur : best;
    end
    return best;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Model update on each active edge.
  always @(posedge clk) begin
    logic [3:0] h;
    h = next_notes[3:0];
    if (reset) begin
      m_score = 0; m_streak = 0; m_mult = 1; m_hits = 0; m_misses = 0;
      m_cnt = 0; m_hit = 0; m_miss = 0; m_done = 0;
      win.delete();
    end else if (!m_done) begin
      m_hit = 0; m_miss = 0;
      win.push_back(detected_valid && detected_note == h && h != 4'd0 && h != 4'd15);
      if (m_cnt >= int'(tempo)) begin
        m_cnt = 0;
        if (h == 4'd15) begin
          m_done = 1;
        end else if (h != 4'd0) begin
          if (longest_run() >= int'(HOLD)) begin
            m_streak = min2(m_streak + 1, 255);
            m_mult   = min2(1 + m_streak / STEP, 4);
            m_score  = min2(m_score + PTS * m_mult, 65535);
            m_hits   = min2(m_hits + 1, 255);
            m_hit    = 1;
          end else begin
            m_streak = 0;
            m_mult   = 1;
            m_misses = min2(m_misses + 1, 255);
            m_miss   = 1;
          end
        end
        win.delete();
      end else begin
        m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("score",      longint'(score),      longint'(m_score));
      chk("streak",     longint'(streak),     longint'(m_streak));
      chk("multiplier", longint'(multiplier), longint'(m_mult));
      chk("hits",       longint'(hits),       longint'(m_hits));
      chk("misses",     longint'(misses),     longint'(m_misses));
      chk("hit_pulse",  longint'(hit_pulse),  longint'(m_hit));
      chk("miss_pulse", longint'(miss_pulse), longint'(m_miss));
      chk("song_done",  longint'(song_done),  longint'(m_done));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_score"},  longint'(score), 0);
    chk({tag, "_streak"}, longint'(streak), 0);
    chk({tag, "_mult"},   longint'(multiplier), 1);
    chk({tag, "_hits"},   longint'(hits), 0);
    chk({tag, "_misses"}, longint'(misses), 0);
    chk({tag, "_pulses"}, longint'({hit_pulse, miss_pulse}), 0);
    chk({tag, "_done"},   longint'(song_done), 0);
  endtask

  // One 11-cycle window at tempo 10; returns just after the beat edge.
  task automatic window(input logic [3:0] h, input logic [3:0] det, input logic [10:0] vmask);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      next_notes      = {$urandom(), $urandom()};
      next_notes[3:0] = h;
      detected_note   = det;
      detected_valid  = vmask[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_const(input int cycles, input logic [3:0] h, input logic [3:0] det);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      next_notes[3:0] = h;
      detected_note   = det;
      detected_valid  = 1'b1;
    end
  endtask

  initial begin
    logic [3:0] cur_head;
    tempo = 26'd10;
    do_reset();
    cmp_en = 1'b1;
    check_reset_values("reset");

    // Basic hit: 4 matching cycles mid-window.
    window(4'd5, 4'd5, 11'b00001111000);
    chk("hit_pulse1", longint'(hit_pulse), 1);
    chk("hit_score",  longint'(score), 10);
    chk("hit_streak", longint'(streak), 1);
    chk("hit_mult",   longint'(multiplier), 1);
    chk("hit_hits",   longint'(hits), 1);

    // Basic miss: wrong pitch all window.
    window(4'd5, 4'd6, 11'h7FF);
    chk("miss_pulse1", longint'(miss_pulse), 1);
    chk("miss_streak", longint'(streak), 0);
    chk("miss_misses", longint'(misses), 1);
    chk("miss_score",  longint'(score), 10);

    // Interrupted hold: runs of 2 only.
    window(4'd5, 4'd5, 11'b00011011000);
    chk("intr_miss",   longint'(miss_pulse), 1);
    chk("intr_misses", longint'(misses), 2);

    // Multiplier growth over 8 hits.
    for (int k = 1; k <= 8; k++) begin
      window(4'd5, 4'd5, 11'h7FF);
      chk("grow_mult", longint'(multiplier), (k < 8) ? 1 : 2);
    end
    chk("grow_score",  longint'(score), 100);
    chk("grow_streak", longint'(streak), 8);

    // Multiplier cap at streak 40.
    for (int k = 9; k <= 40; k++) window(4'd5, 4'd5, 11'h7FF);
    chk("cap_mult",   longint'(multiplier), 4);
    chk("cap_streak", longint'(streak), 40);
    chk("cap_hits",   longint'(hits), 41);

    // Rest note: no judgment.
    window(4'd0, 4'd0, 11'h000);
    chk("rest_pulses", longint'({hit_pulse, miss_pulse}), 0);
    chk("rest_streak", longint'(streak), 40);

    // End of song, then stimulus must not change anything.
    window(4'd15, 4'd15, 11'h7FF);
    chk("end_done", longint'(song_done), 1);
    run_const(40, 4'd5, 4'd5);
    chk("frozen_streak", longint'(streak), 40);
    chk("frozen_hits",   longint'(hits), 41);
    chk("frozen_done",   longint'(song_done), 1);
    do_reset();
    check_reset_values("after_end");

    // Saturation: tempo 3, continuous hits then continuous misses.
    tempo = 26'd3;
    run_const(1700 * 4, 4'd7, 4'd7);
    @(posedge clk); #1;
    chk("sat_score",  longint'(score), 65535);
    chk("sat_streak", longint'(streak), 255);
    chk("sat_hits",   longint'(hits), 255);
    chk("sat_mult",   longint'(multiplier), 4);
    run_const(260 * 4, 4'd7, 4'd8);
    @(posedge clk); #1;
    chk("sat_misses", longint'(misses), 255);
    chk("sat_streak0", longint'(streak), 0);
    chk("sat_mult1",  longint'(multiplier), 1);

    // Randomized phase with tempo changes, rests, song ends and resets.
    do_reset();
    cur_head = 4'd3;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) tempo = 26'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) cur_head = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 299) == 0) cur_head = 4'd15;
      next_notes      = {$urandom(), $urandom()};
      next_notes[3:0] = cur_head;
      detected_note   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : cur_head;
      detected_valid  = ($urandom_range(0, 7) != 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_scorer.md
# note_scorer

Downstream consumer of the musical score loader's 16-note look-ahead window and tempo. On every tempo beat it judges the note currently at the head of the window (nibble 0) against the player's detected pitch and maintains score, streak, multiplier and hit/miss tallies. Score and statistics feed the video display overlay. End of song is flagged when the end-of-song code reaches the head.

## Interface
Parameters:
- POINTS_PER_HIT, 10: base points per judged hit, 8-bit.
- HOLD_MIN, 26'd1_000_000: consecutive matching cycles required for a hit.
- STREAK_STEP, 8: streak length per multiplier increment.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high; must be the same reset that drives the score loader.
- tempo  in  26  cycles per beat, from the loader's tempo output.
- next_notes  in  64  look-ahead window; [3:0] is the current note. Codes: 0 = rest, 1–14 = pitch, 15 = end of song.
- detected_note  in  4  pitch code from the detector.
- detected_valid  in  1  detected_note is meaningful this cycle.
- score  out  16  accumulated score, saturating.
- streak  out  8  consecutive hits, saturating at 255.
- multiplier  out  3  current multiplier, 1–4.
- hits  out  8  judged hits, saturating at 255.
- misses  out  8  judged misses, saturating at 255.
- hit_pulse  out  1  one-cycle strobe per hit.
- miss_pulse  out  1  one-cycle strobe per miss.
- song_done  out  1  level; high once the song has ended.

## Operation
- Beat counter, 26-bit:
  - Increments each cycle in PLAYING.
  - When count >= tempo, `beat` is asserted for that cycle and count clears to 0.
  - The >= compare means a lowered tempo cannot run away. tempo = 0 gives a beat every cycle.
- Match run counter, 26-bit:
  - Increments while detected_valid && detected_note == next_notes[3:0] && next_notes[3:0] not in {0, 15}.
  - Clears on any non-matching cycle.
  - Saturates at HOLD_MIN.
  - `held` flag sets when run == HOLD_MIN and stays set until the next beat.
- Judgment on the beat cycle, using next_notes[3:0] as presented that cycle (the pre-shift note):
  - Note 0: no judgment. Streak unchanged, no pulse.
  - Note 15: go to DONE. No judgment.
  - Note 1–14 with held = 1: hit.
    - streak_n = sat255(streak + 1).
    - mult = min(1 + streak_n / STREAK_STEP, 4).
    - score = sat65535(score + POINTS_PER_HIT × mult).
    - hits++ (saturating). hit_pulse.
  - Note 1–14 with held = 0: miss.
    - streak = 0, mult = 1, misses++ (saturating). miss_pulse.
  - Run counter and held clear on every beat, whether or not a judgment was made.
- States:
  - PLAYING: entered on reset.
  - DONE: entered from PLAYING on a beat with note 15. Left only by reset. In DONE, counters halt, all stats are frozen, pulses stay 0 and song_done = 1.
- Multiplier arithmetic: streak_n / STREAK_STEP is computed at a full 8-bit width, then clamped to 3 before adding 1.

## Timing
- Reset values: score 0, streak 0, multiplier 1, hits 0, misses 0, hit_pulse 0, miss_pulse 0, song_done 0. Beat counter 0, run 0, held 0, state PLAYING.
- All outputs are registered.
- hit_pulse / miss_pulse are high for exactly one cycle: the cycle after the beat cycle.
- score, streak, multiplier and hits/misses update on that same edge.
- song_done rises one cycle after the beat cycle that sees note 15.
- Beat-cycle matching: a match on the beat cycle itself counts toward the closing window. If that match completes HOLD_MIN on the beat cycle, the result is a hit.
- Reset mid-window: all state returns to reset values on the next edge. Reset has priority over beat.
- Loader alignment: the loader shifts its window on its own beat edge, so next_notes[3:0] is stable for the whole window, including the beat cycle.

## Test plan
- Basic hit: tempo = 10, HOLD_MIN = 3, head note 5, detected_note 5 valid for 4 cycles mid-window.
  - Expect: hit_pulse one cycle after beat; score 10, streak 1, multiplier 1, hits 1.
- Basic miss: head note 5, detected 6 for the whole window.
  - Expect: miss_pulse; streak 0, misses 1, score unchanged.
- Interrupted hold: detected 5 for 2 cycles, then invalid 1 cycle, then 5 for 2 cycles.
  - Expect: miss (run never reaches 3).
- Multiplier growth: 8 consecutive hits.
  - Expect: multiplier 1 for hits 1–7, 2 at hit 8.
  - Expect: score 7×10 + 20 = 90, streak 8.
- Multiplier cap: 40 hits.
  - Expect: multiplier saturates at 4, streak 40.
- Rest and end of song: head note 0 for one beat with valid 0 input.
  - Expect: no pulses, streak unchanged.
  - Then head note 15 at the next beat. Expect: song_done = 1 on the next cycle; further stimulus changes nothing until reset, after which all outputs are at reset values.
